seq_binary_multiplier: RTL



---
 rtl/multiplier_pkg.sv | 16 +
 rtl/mult_datapath.sv | 60 ++++++
 rtl/seq_binary_multiplier.sv | 97 +++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller states
// and the sizing rule for the iteration counter.
package multiplier_pkg;

   typedef enum logic [1:0] {
      S_idle  = 2'd0,
      S_add   = 2'd1,
      S_shift = 2'd2
   } state_t;

   // Counter must hold the value dp_width itself, hence the +1.
   function automatic int p_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mult_datapath.sv
// A/B/Q/C register file with iteration counter P; performs load, conditional
// add, and the combined right shift under control of the FSM.
module mult_datapath
   import multiplier_pkg::*;
#(
   parameter int dp_width = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load_regs,
   input  logic                decr_P,
   input  logic                add_regs,
   input  logic                shift_regs,
   input  logic [dp_width-1:0] multiplicand,
   input  logic [dp_width-1:0] multiplier,
   output logic [dp_width-1:0] A,
   output logic [dp_width-1:0] B,
   output logic [dp_width-1:0] Q,
   output logic                C,
   output logic                Q0,
   output logic                Zero
);

   localparam int pw = p_width(dp_width);

   logic [pw-1:0]     P;
   logic [dp_width:0] sum;

   assign sum  = {1'b0, A} + {1'b0, B};
   assign Q0   = Q[0];
   assign Zero = (P == '0);

   // The carry of A+B lands in C, and the shift moves it into the top of A.
   always_ff @(posedge clock) begin
      if (reset) begin
         A <= '0;
         B <= '0;
         Q <= '0;
         C <= 1'b0;
         P <= '0;
      end else if (load_regs) begin
         A <= '0;
         B <= multiplicand;
         Q <= multiplier;
         C <= 1'b0;
         P <= pw'(dp_width);
      end else begin
         if (decr_P) begin
            P <= P - pw'(1);
         end
         if (add_regs) begin
            {C, A} <= sum;
         end
         if (shift_regs) begin
            {C, A, Q} <= {1'b0, C, A, Q[dp_width-1:1]};
         end
      end
   end

endmodule

// File: rtl/seq_binary_multiplier.sv
// Controller for the shift-add multiplier: sequences add/shift pairs over the
// datapath and reports ready/done to the surrounding logic.
module seq_binary_multiplier
   import multiplier_pkg::*;
#(
   parameter int dp_width = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [dp_width-1:0]   multiplicand,
   input  logic [dp_width-1:0]   multiplier,
   output logic                  ready,
   output logic                  done,
   output logic [2*dp_width-1:0] product,
   output logic [dp_width-1:0]   A,
   output logic [dp_width-1:0]   B,
   output logic [dp_width-1:0]   Q,
   output logic                  C
);

   state_t state;
   state_t next_state;
   logic   load_regs;
   logic   decr_P;
   logic   add_regs;
   logic   shift_regs;
   logic   Q0;
   logic   Zero;
   logic   done_next;

   mult_datapath #(.dp_width(dp_width)) u_datapath (
      .clock        (clock),
      .reset        (reset),
      .load_regs    (load_regs),
      .decr_P       (decr_P),
      .add_regs     (add_regs),
      .shift_regs   (shift_regs),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .A            (A),
      .B            (B),
      .Q            (Q),
      .C            (C),
      .Q0           (Q0),
      .Zero         (Zero)
   );

   assign product = {A, Q};
   assign ready   = (state == S_idle);

   // done is registered so it marks the first idle cycle after the last shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_idle;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         done  <= done_next;
      end
   end

   always_comb begin
      next_state = state;
      load_regs  = 1'b0;
      decr_P     = 1'b0;
      add_regs   = 1'b0;
      shift_regs = 1'b0;
      done_next  = 1'b0;
      unique case (state)
         S_idle: begin
            if (start) begin
               load_regs  = 1'b1;
               next_state = S_add;
            end
         end
         S_add: begin
            decr_P     = 1'b1;
            add_regs   = Q0;
            next_state = S_shift;
         end
         S_shift: begin
            shift_regs = 1'b1;
            if (Zero) begin
               next_state = S_idle;
               done_next  = 1'b1;
            end else begin
               next_state = S_add;
            end
         end
         default: begin
            next_state = S_idle;
         end
      endcase
   end

endmodule
